clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter DEB_N, default 4: consecutive clk cycles a synchronized button must be stable before its debounced level changes.
REQ-002 SHALL have parameter RPT_FIRST, default 16: clk cycles from the initial inc press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter RPT_NEXT, default 4: clk cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter BLINK_N, default 8: clk cycles per blink half-period.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-006 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port btn_mode, input, 1 bit: raw, asynchronous mode button, high while pressed.
REQ-008 SHALL have port btn_inc, input, 1 bit: raw, asynchronous increment button, high while pressed.
REQ-009 SHALL have port sec_carry, input, 1 bit: one-cycle pulse from the seconds counter at 59->00.
REQ-010 SHALL have port min_carry, input, 1 bit: one-cycle pulse from the minute counter at 59->00.
REQ-011 SHALL have port min_inc, output, 1 bit: one-cycle increment strobe to the minute counter.
REQ-012 SHALL have port hour_inc, output, 1 bit: one-cycle increment strobe to the BCD 00-23 hour counter.
REQ-013 SHALL have port sec_clr, output, 1 bit: one-cycle clear strobe to the seconds counter.
REQ-014 SHALL have port mode, output, 2 bits: current state, RUN=00, SET_HR=01, SET_MIN=10.
REQ-015 SHALL have port blink, output, 1 bit: display blank enable for the field being set.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer before debouncing.
REQ-017 SHALL change a debounced level only after the synchronized input differs from it for DEB_N consecutive cycles, with the count restarting on any mismatch gap.
REQ-018 SHALL produce a one-cycle press pulse on each 0->1 transition of a debounced level and none on release.
REQ-019 SHALL implement FSM RUN -> SET_HR -> SET_MIN -> RUN, advancing one state per mode press pulse; 11 is unreachable and SHALL recover to RUN on the next cycle.
REQ-020 SHALL in RUN register min_inc = sec_carry and hour_inc = min_carry with exactly 1 cycle of latency, and ignore inc presses.
REQ-021 SHALL in SET_HR and SET_MIN suppress both carries (min_inc and hour_inc never driven from them).
REQ-022 SHALL in SET_HR assert hour_inc, and in SET_MIN assert min_inc, for one cycle in the cycle after each inc press pulse or auto-repeat event.
REQ-023 SHALL, while debounced inc stays high in a SET state, generate an auto-repeat event RPT_FIRST cycles after the press pulse and then every RPT_NEXT cycles.
REQ-024 SHALL clear the repeat counter on inc release or on any state change; a held inc across a state change generates no further strobes until released and pressed again.
REQ-025 SHALL give the mode press priority when it coincides with an inc press or repeat event in the same cycle: state advances and no inc strobe is issued.
REQ-026 SHALL assert sec_clr for one cycle in the cycle after the SET_MIN -> RUN transition and at no other time.
REQ-027 SHALL hold blink 0 in RUN, and in SET states toggle it every BLINK_N cycles starting at 0, with the blink counter restarted on each state change.
REQ-028 SHALL drive all outputs from registers, never combinationally from inputs.

Reset
REQ-029 SHALL, while clr is high, force mode=00, min_inc=0, hour_inc=0, sec_clr=0, blink=0, debounced levels=0, and all counters and synchronizers to 0, independent of clk.
REQ-030 SHALL after clr deasserts, with a button already held, treat it as a new press once it has been debounced, i.e. DEB_N+2 cycles later.

Verification
REQ-031 SHALL be verified with: btn_mode pulse 3 cycles wide -> no state change; held 10 cycles -> mode 00->01 exactly once.
REQ-032 SHALL be verified with: RUN, sec_carry at cycle 10 -> min_inc high at cycle 11 only; in SET_HR the same stimulus -> min_inc stays 0.
REQ-033 SHALL be verified with: SET_HR, btn_inc held 40 cycles -> hour_inc pulses at press+1, +17, +21, +25, +29, +33, +37, +41 relative to the press pulse (8 strobes).
REQ-034 SHALL be verified with: SET_MIN and a mode press -> mode=00, sec_clr high for exactly one cycle, blink=0.
REQ-035 SHALL be verified with: mode and inc press pulses in the same cycle in SET_HR -> mode=10, no hour_inc; clr asserted mid-repeat -> all outputs 0 immediately.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Clock time-set controller: debounced mode/inc buttons, a RUN/SET_HR/SET_MIN
// state machine, inc auto-repeat, carry forwarding in RUN and a field blink.
module clock_set_ctrl #(
  parameter int unsigned DEB_N     = 4,
  parameter int unsigned RPT_FIRST = 16,
  parameter int unsigned RPT_NEXT  = 4,
  parameter int unsigned BLINK_N   = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned DW      = $clog2(DEB_N + 1);
  localparam int unsigned RPT_MAX = (RPT_FIRST > RPT_NEXT) ? RPT_FIRST : RPT_NEXT;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);
  localparam int unsigned BW      = $clog2(BLINK_N + 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    BAD     = 2'b11
  } state_t;

  // index 0 = mode button, index 1 = inc button
  logic [1:0]    raw;
  logic [1:0]    s1, s2, deb, deb_d;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    press;

  state_t        state, state_nxt;
  logic          min_inc_nxt, hour_inc_nxt, sec_clr_nxt;
  logic          state_chg;

  logic          armed, rpt_first_ph, rpt_evt;
  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;

  assign raw       = {btn_inc, btn_mode};
  assign press     = deb & ~deb_d;
  assign state_chg = (state_nxt != state);
  assign mode      = state;

  // Two-flop synchronizers followed by a stable-for-DEB_N-cycles debouncer
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_N - 1)) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // Auto-repeat: armed by an inc press in a SET state, dropped on release or state change
  assign rpt_evt = armed & deb[1] &
                   (rcnt == (rpt_first_ph ? RW'(RPT_FIRST) : RW'(RPT_NEXT)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      armed        <= 1'b0;
      rpt_first_ph <= 1'b0;
      rcnt         <= '0;
    end else if (state_chg || !deb[1]) begin
      armed        <= 1'b0;
      rpt_first_ph <= 1'b0;
      rcnt         <= '0;
    end else if (press[1] && state != RUN) begin
      armed        <= 1'b1;
      rpt_first_ph <= 1'b1;
      rcnt         <= RW'(1);
    end else if (armed) begin
      if (rpt_evt) begin
        rcnt         <= RW'(1);
        rpt_first_ph <= 1'b0;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

  // Next state and strobe decode; a mode press always wins over inc activity
  always_comb begin
    state_nxt    = state;
    min_inc_nxt  = 1'b0;
    hour_inc_nxt = 1'b0;
    sec_clr_nxt  = 1'b0;
    case (state)
      RUN: begin
        min_inc_nxt  = sec_carry;
        hour_inc_nxt = min_carry;
        if (press[0]) state_nxt = SET_HR;
      end
      SET_HR: begin
        if (press[0]) state_nxt = SET_MIN;
        else          hour_inc_nxt = press[1] | rpt_evt;
      end
      SET_MIN: begin
        if (press[0]) begin
          state_nxt   = RUN;
          sec_clr_nxt = 1'b1;
        end else begin
          min_inc_nxt = press[1] | rpt_evt;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and strobe registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= RUN;
      min_inc  <= 1'b0;
      hour_inc <= 1'b0;
      sec_clr  <= 1'b0;
    end else begin
      state    <= state_nxt;
      min_inc  <= min_inc_nxt;
      hour_inc <= hour_inc_nxt;
      sec_clr  <= sec_clr_nxt;
    end
  end

  // Blink half-period timer, restarted on every state change and idle in RUN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (state_chg || state == RUN) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == BW'(BLINK_N - 1)) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button/carry
// traffic, checked cycle by cycle against a behavioural model via a queue.
module tb_clock_set_ctrl;

  localparam int DEB_N     = 4;
  localparam int RPT_FIRST = 16;
  localparam int RPT_NEXT  = 4;
  localparam int BLINK_N   = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_carry = 1'b0;
  logic       min_carry = 1'b0;
  logic       min_inc, hour_inc, sec_clr, blink;
  logic [1:0] mode;

  int n_pass = 0;
  int n_chk  = 0;

  logic [5:0] exp_q[$];

  clock_set_ctrl #(
    .DEB_N(DEB_N), .RPT_FIRST(RPT_FIRST), .RPT_NEXT(RPT_NEXT), .BLINK_N(BLINK_N)
  ) dut (
    .clk(clk), .clr(clr), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_carry(sec_carry), .min_carry(min_carry), .min_inc(min_inc),
    .hour_inc(hour_inc), .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [DEB_N+1:0] hm_q, hi_q;   // raw button samples, bit 0 newest
  logic             md, md_p, id, id_p, arm;
  int               age, bage;
  logic [1:0]       st;

  task automatic model_reset();
    hm_q = '0; hi_q = '0;
    md = 1'b0; md_p = 1'b0; id = 1'b0; id_p = 1'b0; arm = 1'b0;
    age = 0; bage = 0; st = 2'b00;
  endtask

  // A level flips once the DEB_N synchronized samples all disagree with it
  function automatic logic settle(input logic [DEB_N+1:0] h, input logic cur);
    logic all_diff;
    all_diff = 1'b1;
    for (int k = 2; k <= DEB_N + 1; k++) if (h[k] == cur) all_diff = 1'b0;
    return all_diff ? ~cur : cur;
  endfunction

  task automatic model_step();
    logic mp, ip, ev, mi, hi, sc, bl;
    logic [1:0] ns;
    if (clr) begin
      model_reset();
      exp_q.push_back(6'd0);
      return;
    end
    mp = md & ~md_p;
    ip = id & ~id_p;
    ev = arm && id && (age >= RPT_FIRST) && (((age - RPT_FIRST) % RPT_NEXT) == 0);
    ns = st; mi = 1'b0; hi = 1'b0; sc = 1'b0;
    case (st)
      2'b00: begin
        mi = sec_carry;
        hi = min_carry;
        if (mp) ns = 2'b01;
      end
      2'b01: if (mp) ns = 2'b10; else hi = ip | ev;
      default: if (mp) begin ns = 2'b00; sc = 1'b1; end else mi = ip | ev;
    endcase
    bage = (ns != st) ? 0 : bage + 1;
    bl   = (ns != 2'b00) && (((bage / BLINK_N) % 2) == 1);
    arm  = (arm || (ip && st != 2'b00)) && !mp;
    hm_q = {hm_q[DEB_N:0], btn_mode};
    hi_q = {hi_q[DEB_N:0], btn_inc};
    md_p = md; md = settle(hm_q, md);
    id_p = id; id = settle(hi_q, id);
    if (!id) arm = 1'b0;
    if (id && !id_p) age = 0;
    else if (age < 1000000) age = age + 1;
    st = ns;
    exp_q.push_back({ns, mi, hi, sc, bl});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare every presented output cycle against the model
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 32'({mode, min_inc, hour_inc, sec_clr, blink}), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(8);
    btn_mode = 1'b0; cyc(10);
  endtask

  initial begin
    int nsc, nh, first, last, hm, hi;
    cyc(3);
    check("reset_outputs", 32'({mode, min_inc, hour_inc, sec_clr, blink}), 32'd0);
    clr = 1'b0; cyc(2);

    // Short glitch is filtered, a long hold advances exactly once
    btn_mode = 1'b1; cyc(3); btn_mode = 1'b0; cyc(12);
    check("glitch_mode", 32'(mode), 32'd0);
    btn_mode = 1'b1; cyc(10); btn_mode = 1'b0; cyc(12);
    check("held_mode", 32'(mode), 32'd1);
    press_mode();
    check("to_set_min", 32'(mode), 32'd2);

    // Leave SET_MIN: one sec_clr strobe, back in RUN with blink off
    nsc = 0; btn_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) btn_mode = 1'b0;
      cyc(1);
      if (sec_clr) nsc++;
    end
    check("sec_clr_count", 32'(nsc), 32'd1);
    check("exit_mode", 32'(mode), 32'd0);
    check("exit_blink", 32'(blink), 32'd0);

    // Carry forwarding in RUN, suppression in SET_HR
    sec_carry = 1'b1; cyc(1);
    check("run_min_inc", 32'(min_inc), 32'd1);
    sec_carry = 1'b0; cyc(1);
    check("run_min_inc_drop", 32'(min_inc), 32'd0);
    min_carry = 1'b1; cyc(1);
    check("run_hour_inc", 32'(hour_inc), 32'd1);
    min_carry = 1'b0; cyc(1);
    press_mode();
    check("to_set_hr", 32'(mode), 32'd1);
    sec_carry = 1'b1; min_carry = 1'b1; cyc(1);
    check("set_carry_blocked", 32'({min_inc, hour_inc}), 32'd0);
    sec_carry = 1'b0; min_carry = 1'b0; cyc(1);

    // Held inc in SET_HR: press strobe plus seven repeats, 40 cycles apart end to end
    nh = 0; first = -1; last = -1;
    for (int i = 0; i < 60; i++) begin
      btn_inc = (i < 42);
      cyc(1);
      if (hour_inc) begin
        nh++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("rpt_count", 32'(nh), 32'd8);
    check("rpt_span", 32'(last - first), 32'd40);

    // Coincident mode and inc presses: mode wins, no hour strobe
    nh = 0; btn_mode = 1'b1; btn_inc = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) begin btn_mode = 1'b0; btn_inc = 1'b0; end
      cyc(1);
      if (hour_inc) nh++;
    end
    check("coincide_no_hour_inc", 32'(nh), 32'd0);
    check("coincide_mode", 32'(mode), 32'd2);
    press_mode();
    press_mode();

    // Asynchronous clear in the middle of an auto-repeat
    btn_inc = 1'b1; cyc(30);
    clr = 1'b1; #1;
    check("clr_async", 32'({mode, min_inc, hour_inc, sec_clr, blink}), 32'd0);
    cyc(2); clr = 1'b0; cyc(20);
    btn_inc = 1'b0; cyc(12);
    check("inc_ignored_run", 32'(mode), 32'd0);

    // Button held through clear becomes a fresh press afterwards
    btn_mode = 1'b1; cyc(3);
    clr = 1'b1; cyc(2); clr = 1'b0; cyc(12);
    check("held_through_clr", 32'(mode), 32'd1);
    btn_mode = 1'b0; cyc(10);

    // Random traffic
    hm = 0; hi = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hm == 0) begin
        btn_mode = ($urandom_range(0, 3) == 0);
        hm = int'($urandom_range(1, 20));
      end else hm--;
      if (hi == 0) begin
        btn_inc = ($urandom_range(0, 1) == 0);
        hi = int'($urandom_range(1, 60));
      end else hi--;
      sec_carry = ($urandom_range(0, 7) == 0);
      min_carry = ($urandom_range(0, 7) == 0);
      clr       = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    clr = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; sec_carry = 1'b0; min_carry = 1'b0;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
